// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit (optional MULDIV_EARLY_OUT_EN zero-operand shortcut)
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    input  logic        mf_sel,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi, lo;
    logic [31:0] a_reg, b_reg;
    logic [63:0] acc;
    logic        is_div, neg_a, neg_b, zero_op;

    logic        rs_neg, rt_neg, launch_zero;
    logic [31:0] rs_abs, rt_abs;

    assign rs_neg      = ~op[0] & rs_val[31];
    assign rt_neg      = ~op[0] & rt_val[31];
    assign rs_abs      = rs_neg ? -rs_val : rs_val;
    assign rt_abs      = rt_neg ? -rt_val : rt_val;
    assign launch_zero = op[1] ? (rt_val == 32'd0) : ((rs_val == 32'd0) || (rt_val == 32'd0));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    logic [64:0] mul_shift;
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_reg} : 33'd0);
    assign mul_shift = {mul_sum, acc[31:0]} >> 1;

    // Divide: acc = {remainder, dividend/quotient bits}, restoring subtract after left shift.
    logic [64:0] div_sh;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    assign div_sh    = {acc, 1'b0};
    assign div_trial = div_sh[64:32] - {1'b0, b_reg};
    assign div_next  = div_trial[32] ? div_sh[63:0] : {div_trial[31:0], div_sh[31:1], 1'b1};

    logic [63:0] prod;
    logic [31:0] quot, rem, res_hi, res_lo;
    assign prod = (neg_a ^ neg_b) ? -acc : acc;
    assign quot = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
    assign rem  = neg_a ? -acc[63:32] : acc[63:32];

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            // a_reg keeps the raw dividend for divides so divide-by-zero can return it.
            res_hi = zero_op ? a_reg : rem;
            res_lo = zero_op ? 32'hFFFF_FFFF : quot;
        end
    end

    assign busy    = (state != S_IDLE);
    assign stall   = busy & (start | mf_req | mt_we);
    assign mf_data = mf_sel ? lo : hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            acc     <= 64'd0;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            zero_op <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_a   <= rs_neg;
                        neg_b   <= rt_neg;
                        zero_op <= launch_zero;
                        cnt     <= 5'd0;
                        a_reg   <= op[1] ? rs_val : rs_abs;
                        b_reg   <= rt_abs;
                        acc     <= op[1] ? {32'd0, rs_abs} : {32'd0, rt_abs};
`ifdef MULDIV_EARLY_OUT_EN
                        state   <= launch_zero ? S_FIN : S_RUN;
                        if (launch_zero && !op[1])
                            acc <= 64'd0;
`else
                        state   <= S_RUN;
`endif
                    end else if (mt_we) begin
                        if (mt_sel)
                            lo <= mt_data;
                        else
                            hi <= mt_data;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_shift[63:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= S_FIN;
                end
                S_FIN: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and randomized checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        mf_req, mf_sel, mt_we, mt_sel;
    logic [31:0] mt_data;
    logic [31:0] mf_data;
    logic        busy, stall, done;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mf_req(mf_req), .mf_sel(mf_sel),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .mf_data(mf_data), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV / and % truncate toward zero.
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo, output int elat);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        elat = 33;
        case (mop)
            2'b00: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
            2'b01: begin u = {32'd0, a} * {32'd0, b}; ehi = u[63:32]; elo = u[31:0]; end
            2'b10: begin
                if (b == 0) begin ehi = a; elo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; ehi = r[31:0]; elo = q[31:0]; end
            end
            default: begin
                if (b == 0) begin ehi = a; elo = 32'hFFFF_FFFF; end
                else begin ehi = a % b; elo = a / b; end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if ((mop[1] && b == 0) || (!mop[1] && (a == 0 || b == 0)))
            elat = 1;
`endif
    endtask

    task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mt);
        logic [31:0] ehi, elo;
        int elat, n;
        model(mop, a, b, ehi, elo, elat);
        op = mop; rs_val = a; rt_val = b; start = 1'b1;
        mt_we = with_mt; mt_sel = 1'b0; mt_data = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        start = 1'b0; mt_we = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk("latency", n, elat);
        chk("busy_at_done", busy, 0);
        mf_sel = 1'b0; #1;
        chk("hi", mf_data, ehi);
        mf_sel = 1'b1; #1;
        chk("lo", mf_data, elo);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 0; rt_val = 0;
        mf_req = 1'b0; mf_sel = 1'b0; mt_we = 1'b0; mt_sel = 1'b0; mt_data = 0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hi", mf_data, 0);
        mf_sel = 1'b1; #1;
        chk("rst_lo", mf_data, 0);

        // First edge after release must accept the launch.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'd0, 32'h1234_5678, 1'b0);

        // Direct HI/LO writes in IDLE.
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h1234_5678;
        @(posedge clk); #1;
        mt_sel = 1'b1; mt_data = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        mt_we = 1'b0; mf_sel = 1'b0; #1;
        chk("mthi", mf_data, 32'h1234_5678);
        mf_sel = 1'b1; #1;
        chk("mtlo", mf_data, 32'h9ABC_DEF0);

        // start and mt_we together: the write is dropped.
        run_op(2'b11, 32'd1000, 32'd3, 1'b1);

        // MULTU 6x7 with mf_req, mt_we and a second start arriving while busy.
        op = 2'b01; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin mf_req = 1'b1; mf_sel = 1'b1; end
            if (k == 9) begin mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEAD_BEEF; end
            if (k == 10) mt_we = 1'b0;
            if (k == 15) begin start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; end
            if (k == 17) start = 1'b0;
            if (k >= 5 && k <= 32) chk("stall_while_busy", stall, 1);
        end
        chk("stall_released", stall, 0);
        chk("done_e33", done, 1);
        chk("mf_lo_42", mf_data, 32'd42);
        mf_req = 1'b0; mf_sel = 1'b0; #1;
        chk("mf_hi_0", mf_data, 32'd0);
        @(posedge clk); #1;
        chk("no_relaunch", busy, 0);

        // Reset in the middle of a DIV.
        op = 2'b10; rs_val = 32'd77; rt_val = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        mf_sel = 1'b0; #1;
        chk("midrst_hi", mf_data, 0);
        mf_sel = 1'b1; #1;
        chk("midrst_lo", mf_data, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 32'hFFFF_FF00, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(rop, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
